apb_bridge_nslot: RTL and testbench
===================================

# apb_bridge_nslot

Parametrised AHB-Lite slave to APB4 master bridge, successor to the fixed 16-slot bridge used in the BFM APB wrapper. It accepts single AHB-Lite transfers, decodes a configurable number of APB slots, and runs one APB4 transfer per AHB transfer. It adds PSTRB byte lanes, PREADY wait states with a timeout, and PSLVERR/decode/size faults mapped to a two-cycle AHB ERROR response. It sits between an AHB master (BFM or CPU) and the APB peripheral bus.

## Interface
Parameters:
- NUM_SLOTS, 16, number of APB slots, 1..16; width of PSEL.
- SLOT_ADDR_LSB, 24, LSB of the 4-bit slot index field HADDR[SLOT_ADDR_LSB+3:SLOT_ADDR_LSB], range 4..28.
- APB_TIMEOUT, 256, maximum ACCESS cycles before abort, 2..65535; 0 disables the timeout.

Ports:
- HCLK  in  1  single clock for both buses.
- HRESETN  in  1  asynchronous, active-low reset.
- HSEL  in  1  bridge selected.
- HADDR  in  32  AHB address.
- HWRITE  in  1  AHB write.
- HTRANS  in  2  AHB transfer type.
- HSIZE  in  3  AHB size.
- HWDATA  in  32  AHB write data.
- HREADYIN  in  1  bus HREADY.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- PSEL  out  NUM_SLOTS  one-hot slot select.
- PADDR  out  32  {zeros, HADDR[SLOT_ADDR_LSB-1:0]}.
- PWRITE  out  1  APB write.
- PENABLE  out  1  APB access phase.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  write byte strobes.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

## Operation
- Accept condition: HSEL & HREADYIN & HTRANS[1] while HREADYOUT=1. On the accepting edge the bridge registers HADDR, HWRITE and HSIZE. IDLE and BUSY transfers are ignored.
- FSM states: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - HREADYOUT=1, HRESP=0.
  - Accept → LATCH.
- LATCH:
  - HREADYOUT=0; HWDATA is captured into PWDATA on exit.
  - Fault → ERR1 with no APB activity. Faults: slot index ≥ NUM_SLOTS, HSIZE>2, or a misaligned address (halfword with HADDR[0]=1, word with HADDR[1:0]≠0).
  - Otherwise → SETUP.
- SETUP:
  - PSEL[slot]=1, PENABLE=0.
  - → ACCESS.
- ACCESS:
  - PENABLE=1; the cycle counter increments each cycle.
  - PREADY=1 & PSLVERR=0 → IDLE; on a read, HRDATA←PRDATA.
  - PREADY=1 & PSLVERR=1 → ERR1; HRDATA unchanged.
  - PREADY=0 with counter = APB_TIMEOUT-1 → ERR1, abort.
  - PSEL and PENABLE drop on exit in every case.
  - PREADY=1 in the timeout cycle counts as a normal completion.
- ERR1: HREADYOUT=0, HRESP=1 → ERR2.
- ERR2:
  - HREADYOUT=1, HRESP=1 → IDLE.
  - An accept in ERR2 is honoured and goes → LATCH.
- PSTRB rules:
  - Reads: 0.
  - HSIZE=0: 1<<HADDR[1:0].
  - HSIZE=1: 4'b0011<<{HADDR[1],1'b0}.
  - HSIZE=2: 4'b1111.
- Held values:
  - PADDR, PWRITE, PWDATA and PSTRB hold between transfers.
  - PSEL is all-zero outside SETUP/ACCESS.
  - HRDATA changes only on a successful read completion.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0; state IDLE, counter 0.
- Reset asserted mid-transfer clears all outputs immediately (asynchronously) with no completion.
- All outputs are registered; no combinational path from AHB inputs to APB outputs.
- Cycle timing, accept on edge E0:
  - LATCH occupies cycle 1.
  - SETUP occupies cycle 2.
  - ACCESS starts in cycle 3.
  - With PREADY=1 in cycle 3, HREADYOUT=1 in cycle 4, completing the data phase: 3 wait states minimum.
  - Each PREADY=0 cycle adds one wait state.
- Back-to-back: the completing IDLE cycle may accept the next address phase, giving one transfer per 4 cycles at zero APB waits.
- Error response: HREADYOUT=0/HRESP=1 for one cycle, then HREADYOUT=1/HRESP=1 for one cycle (AHB-Lite compliant).
- Decode or size fault: ERR1 in cycle 2, ERR2 in cycle 3.
- APB signals remain stable from SETUP through the final ACCESS cycle.

## Test plan
- Reset and write: word write 0xDEADBEEF to slot 3 offset 0x10 (HADDR=0x0300_0010), PREADY=1.
  - Expect PSEL=0x0008, PADDR=0x10, PSTRB=0xF, PWDATA=0xDEADBEEF.
  - Expect HREADYOUT low for exactly 3 cycles and HRESP=0.
- Read with waits: read slot 0, PREADY low for 5 ACCESS cycles, PRDATA=0x1234_5678.
  - Expect 8 wait states and HRDATA=0x12345678 in the completing cycle.
- Byte and halfword strobes: byte write at HADDR[1:0]=2 gives PSTRB=0x4; halfword at HADDR[1:0]=2 gives PSTRB=0xC.
  - Halfword at HADDR[1:0]=1 gives an ERROR response with no PSEL pulse.
- Slave and decode errors:
  - PSLVERR=1 with PREADY=1 → two-cycle ERROR, HRDATA unchanged.
  - NUM_SLOTS=4 with slot index 5 → ERROR, PSEL never asserted.
- Timeout: APB_TIMEOUT=8, PREADY held 0.
  - Expect PENABLE high exactly 8 cycles, then ERROR.
  - With PREADY rising in the 8th cycle instead, expect a normal OKAY completion.
- Back-to-back and reset: 16 pipelined writes at zero wait complete at one per 4 cycles.
  - Asserting HRESETN=0 during ACCESS clears PSEL and PENABLE and sets HREADYOUT=1 immediately.

Source files
------------

// File: rtl/apb_bridge_nslot.sv
// AHB-Lite slave to APB4 master bridge with a parametrised slot decode,
// byte strobes, PREADY wait states with timeout, and two-cycle ERROR responses.
module apb_bridge_nslot #(
    parameter int NUM_SLOTS     = 16,
    parameter int SLOT_ADDR_LSB = 24,
    parameter int APB_TIMEOUT   = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [NUM_SLOTS-1:0] PSEL,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

    localparam logic        TO_EN   = (APB_TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(APB_TIMEOUT - 1);

    state_t         state_reg;
    logic [31:0]    haddr_reg;
    logic           hwrite_reg;
    logic [2:0]     hsize_reg;
    logic [15:0]    cnt_reg;

    logic [3:0]           slot;
    logic                 slot_bad;
    logic                 misalign;
    logic                 fault;
    logic                 accept;
    logic [NUM_SLOTS-1:0] psel_next;
    logic [3:0]           pstrb_next;
    logic [31:0]          paddr_next;
    logic                 unused_ok;

    assign slot       = haddr_reg[SLOT_ADDR_LSB +: 4];
    assign slot_bad   = ({1'b0, slot} >= 5'(NUM_SLOTS));
    assign misalign   = ((hsize_reg == 3'd1) && haddr_reg[0]) ||
                        ((hsize_reg == 3'd2) && (haddr_reg[1:0] != 2'b00));
    assign fault      = slot_bad || (hsize_reg > 3'd2) || misalign;
    assign accept     = HSEL && HREADYIN && HTRANS[1] && HREADYOUT;
    assign paddr_next = {{(32-SLOT_ADDR_LSB){1'b0}}, haddr_reg[SLOT_ADDR_LSB-1:0]};
    assign unused_ok  = ^{haddr_reg[31:SLOT_ADDR_LSB], HTRANS[0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_psel
            assign psel_next[gi] = (slot == 4'(gi));
        end
    endgenerate

    always_comb begin
        pstrb_next = 4'b0000;
        if (hwrite_reg) begin
            case (hsize_reg)
                3'd0:    pstrb_next = 4'b0001 << haddr_reg[1:0];
                3'd1:    pstrb_next = 4'b0011 << {haddr_reg[1], 1'b0};
                3'd2:    pstrb_next = 4'b1111;
                default: pstrb_next = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_reg  <= IDLE;
            haddr_reg  <= '0;
            hwrite_reg <= 1'b0;
            hsize_reg  <= '0;
            cnt_reg    <= '0;
            HREADYOUT  <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= '0;
            PSEL       <= '0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PENABLE    <= 1'b0;
            PWDATA     <= '0;
            PSTRB      <= '0;
        end else begin
            case (state_reg)
                // ERR2 already drives HREADYOUT=1, so it can take a new address phase
                IDLE, ERR2: begin
                    HRESP <= 1'b0;
                    if (accept) begin
                        haddr_reg  <= HADDR;
                        hwrite_reg <= HWRITE;
                        hsize_reg  <= HSIZE;
                        HREADYOUT  <= 1'b0;
                        state_reg  <= LATCH;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
                LATCH: begin
                    PWDATA <= HWDATA;
                    if (fault) begin
                        HRESP     <= 1'b1;
                        state_reg <= ERR1;
                    end else begin
                        PSEL      <= psel_next;
                        PADDR     <= paddr_next;
                        PWRITE    <= hwrite_reg;
                        PSTRB     <= pstrb_next;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE   <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            HRESP     <= 1'b1;
                            state_reg <= ERR1;
                        end else begin
                            if (!hwrite_reg) HRDATA <= PRDATA;
                            HREADYOUT <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else if (TO_EN && (cnt_reg == TO_LAST)) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        HRESP     <= 1'b1;
                        state_reg <= ERR1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ERR1: begin
                    HREADYOUT <= 1'b1;
                    state_reg <= ERR2;
                end
                default: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_nslot.sv
// Directed bench for apb_bridge_nslot: 4 slots, timeout 8, behavioural APB slave
// whose PREADY delay, PSLVERR and PRDATA are set per transfer.
module tb_apb_bridge_nslot;

    localparam int NS = 4;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = '0;
    logic          HWRITE = 1'b0;
    logic [1:0]    HTRANS = '0;
    logic [2:0]    HSIZE = '0;
    logic [31:0]   HWDATA = '0;
    logic          HREADYIN = 1'b1;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [NS-1:0] PSEL;
    logic [31:0]   PADDR;
    logic          PWRITE;
    logic          PENABLE;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int          wait_cfg = 0;
    logic        slverr_cfg = 1'b0;
    logic [31:0] prdata_cfg = '0;

    int n_checks = 0;
    int n_fail = 0;

    apb_bridge_nslot #(.NUM_SLOTS(NS), .SLOT_ADDR_LSB(24), .APB_TIMEOUT(8)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL),
        .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    // APB slave model: PREADY rises after wait_cfg low ACCESS cycles
    int acc_cnt = 0;
    assign PREADY  = PENABLE && (acc_cnt >= wait_cfg);
    assign PSLVERR = PENABLE && slverr_cfg;
    assign PRDATA  = prdata_cfg;

    int            cyc = 0;
    int            psel_total = 0;
    int            pen_total = 0;
    logic [NS-1:0] cap_psel = '0;
    logic [31:0]   cap_paddr = '0;
    logic [31:0]   cap_pwdata = '0;
    logic [3:0]    cap_pstrb = '0;
    logic          cap_pwrite = 1'b0;

    always @(posedge HCLK) begin
        cyc <= cyc + 1;
        if (PSEL != '0) psel_total <= psel_total + 1;
        if (PENABLE) pen_total <= pen_total + 1;
        if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if ((PSEL != '0) && !PENABLE) begin
            cap_psel   <= PSEL;
            cap_paddr  <= PADDR;
            cap_pwdata <= PWDATA;
            cap_pstrb  <= PSTRB;
            cap_pwrite <= PWRITE;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one address phase now, accepts on the next edge, then counts wait states
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output int waits, output logic err,
                        output logic [31:0] rdata, output int pen, output int psl);
        int   pen0;
        int   psl0;
        logic done;
        pen0 = pen_total;
        psl0 = psel_total;
        HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = 2'b10; HSIZE = size;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        waits = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge HCLK);
            if (HREADYOUT) done = 1'b1;
            else waits++;
        end
        if (!done) check_val("hready_bound", {31'd0, HREADYOUT}, 32'd1);
        err   = HRESP;
        rdata = HRDATA;
        pen   = pen_total - pen0;
        psl   = psel_total - psl0;
        $display("xfer addr=0x%08h wr=%0d size=%0d waits=%0d resp=%0d rdata=0x%08h",
                 addr, wr, size, waits, err, rdata);
    endtask

    int          w;
    int          pen;
    int          psl;
    int          c0;
    logic        e;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge HCLK);
        check_val("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check_val("rst_hresp", {31'd0, HRESP}, 32'd0);
        check_val("rst_hrdata", HRDATA, 32'd0);
        check_val("rst_psel", {28'd0, PSEL}, 32'd0);
        check_val("rst_penable", {31'd0, PENABLE}, 32'd0);
        check_val("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        check_val("rst_paddr", PADDR, 32'd0);
        check_val("rst_pwdata", PWDATA, 32'd0);
        check_val("rst_pstrb", {28'd0, PSTRB}, 32'd0);
        HRESETN = 1'b1;
        @(negedge HCLK);

        // word write, zero APB waits
        xfer(32'h0300_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, w, e, rd, pen, psl);
        check_val("wr_waits", w, 3);
        check_val("wr_resp", {31'd0, e}, 0);
        check_val("wr_psel", {28'd0, cap_psel}, 32'h8);
        check_val("wr_paddr", cap_paddr, 32'h10);
        check_val("wr_pstrb", {28'd0, cap_pstrb}, 32'hF);
        check_val("wr_pwdata", cap_pwdata, 32'hDEAD_BEEF);
        check_val("wr_pwrite", {31'd0, cap_pwrite}, 1);
        check_val("wr_penable_cyc", pen, 1);

        // read with 5 PREADY-low cycles
        wait_cfg = 5; prdata_cfg = 32'h1234_5678;
        xfer(32'h0000_0020, 1'b0, 3'd2, 32'h0, w, e, rd, pen, psl);
        check_val("rd_waits", w, 8);
        check_val("rd_hrdata", rd, 32'h1234_5678);
        check_val("rd_resp", {31'd0, e}, 0);
        check_val("rd_pstrb", {28'd0, cap_pstrb}, 32'h0);
        check_val("rd_penable_cyc", pen, 6);

        // byte and halfword strobes, then a misaligned halfword
        wait_cfg = 0;
        xfer(32'h0200_0002, 1'b1, 3'd0, 32'h00AB_0000, w, e, rd, pen, psl);
        check_val("byte_pstrb", {28'd0, cap_pstrb}, 32'h4);
        check_val("byte_psel", {28'd0, cap_psel}, 32'h4);
        check_val("byte_paddr", cap_paddr, 32'h2);
        xfer(32'h0200_0002, 1'b1, 3'd1, 32'hBEEF_0000, w, e, rd, pen, psl);
        check_val("half_pstrb", {28'd0, cap_pstrb}, 32'hC);
        check_val("half_waits", w, 3);
        xfer(32'h0100_0001, 1'b1, 3'd1, 32'h0, w, e, rd, pen, psl);
        check_val("misal_resp", {31'd0, e}, 1);
        check_val("misal_waits", w, 2);
        check_val("misal_psel_cyc", psl, 0);

        // slave error on a read: accepted straight from ERR2
        slverr_cfg = 1'b1; prdata_cfg = 32'hAAAA_5555;
        xfer(32'h0100_0004, 1'b0, 3'd2, 32'h0, w, e, rd, pen, psl);
        check_val("slverr_resp", {31'd0, e}, 1);
        check_val("slverr_waits", w, 4);
        check_val("slverr_hrdata", rd, 32'h1234_5678);
        slverr_cfg = 1'b0;

        // decode fault (slot 5 of 4) and size fault
        xfer(32'h0500_0000, 1'b1, 3'd2, 32'h0, w, e, rd, pen, psl);
        check_val("decode_resp", {31'd0, e}, 1);
        check_val("decode_waits", w, 2);
        check_val("decode_psel_cyc", psl, 0);
        xfer(32'h0000_0000, 1'b1, 3'd3, 32'h0, w, e, rd, pen, psl);
        check_val("size_resp", {31'd0, e}, 1);
        check_val("size_psel_cyc", psl, 0);

        // timeout abort, then PREADY in the final allowed cycle
        wait_cfg = 1000;
        xfer(32'h0000_0000, 1'b0, 3'd2, 32'h0, w, e, rd, pen, psl);
        check_val("to_penable_cyc", pen, 8);
        check_val("to_resp", {31'd0, e}, 1);
        check_val("to_waits", w, 11);
        wait_cfg = 7; prdata_cfg = 32'hCAFE_F00D;
        xfer(32'h0000_0000, 1'b0, 3'd2, 32'h0, w, e, rd, pen, psl);
        check_val("to8_penable_cyc", pen, 8);
        check_val("to8_resp", {31'd0, e}, 0);
        check_val("to8_waits", w, 10);
        check_val("to8_hrdata", rd, 32'hCAFE_F00D);

        // 16 back-to-back writes at zero wait
        wait_cfg = 0;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            a = (32'(i % 4) << 24) | 32'(i * 4);
            d = 32'(i) * 32'h0101_0101 + 32'h10;
            xfer(a, 1'b1, 3'd2, d, w, e, rd, pen, psl);
            check_val("b2b_waits", w, 3);
            check_val("b2b_resp", {31'd0, e}, 0);
            check_val("b2b_pwdata", cap_pwdata, d);
        end
        check_val("b2b_span", cyc - c0, 64);

        // reset asserted mid-ACCESS
        wait_cfg = 1000;
        HSEL = 1'b1; HADDR = 32'h0100_0000; HWRITE = 1'b1; HTRANS = 2'b10; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        for (int i = 0; i < 20 && !PENABLE; i++) @(negedge HCLK);
        check_val("mid_penable", {31'd0, PENABLE}, 1);
        #2;
        HRESETN = 1'b0;
        #1;
        check_val("arst_psel", {28'd0, PSEL}, 32'h0);
        check_val("arst_penable", {31'd0, PENABLE}, 0);
        check_val("arst_hreadyout", {31'd0, HREADYOUT}, 1);
        check_val("arst_hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        HRESETN = 1'b1;
        wait_cfg = 0;
        @(negedge HCLK);
        xfer(32'h0200_0008, 1'b1, 3'd2, 32'h5A5A_5A5A, w, e, rd, pen, psl);
        check_val("post_rst_waits", w, 3);
        check_val("post_rst_pwdata", cap_pwdata, 32'h5A5A_5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
